hazard_scheduler: RTL and testbench

Pipeline hazard scheduler for the 5-stage MIPS core.
- Consumes the ID-stage hazard qualifiers from the instruction decoder: read enables, write-back enable, load flag and resolved destination register.
- Tracks in-flight writers in EX, MEM and WB with a 3-slot scoreboard.
- Produces operand forwarding selects, the load-use stall, taken-branch/jump flushes, a memory-wait freeze and a stall counter.

---
 rtl/hazard_scheduler.sv | 156 +++++++++++++++
 tb/tb_hazard_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler for the 5-stage MIPS core.
//
// Tracks the writers sitting in EX, MEM and WB in a 3-slot scoreboard and
// decides, purely combinationally from those slots and the ID qualifiers,
// the operand forwarding selects, the load-use stall, the redirect flush and
// the memory-wait freeze. A saturating counter totals the stalled cycles.
//
// Ports:
//   i_clk, i_rst          core clock, synchronous active-high reset
//   i_id_*                ID-stage qualifiers (valid, sources, read enables,
//                         write-back enable, load flag, destination)
//   i_branch_taken/i_jump EX-stage redirect requests
//   i_mem_ready           data memory done; low freezes the pipe
//   o_fwd_a/o_fwd_b       operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
//   o_stall_if/o_stall_id hold PC+IF/ID and ID
//   o_flush_if            squash IF/ID
//   o_issue               ID instruction enters EX this cycle
//   o_stall_count         saturating count of stall_id cycles
module hazard_scheduler #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16,
  parameter bit          WB_FWD = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_re1,
  input  logic             i_id_re2,
  input  logic             i_id_we,
  input  logic             i_id_lw,
  input  logic [REG_W-1:0] i_id_wreg,
  input  logic             i_branch_taken,
  input  logic             i_jump,
  input  logic             i_mem_ready,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_flush_if,
  output logic             o_issue,
  output logic [CNT_W-1:0] o_stall_count
);

  // Scoreboard slots
  logic             r_ex_v, r_ex_we, r_ex_lw;
  logic [REG_W-1:0] r_ex_wreg;
  logic             r_mem_v, r_mem_we, r_mem_lw;
  logic [REG_W-1:0] r_mem_wreg;
  logic             r_wb_v, r_wb_we, r_wb_lw;
  logic [REG_W-1:0] r_wb_wreg;
  logic [CNT_W-1:0] r_stall_count;

  // A slot is a forwarding candidate only if it writes a non-zero register.
  logic w_ex_wr, w_mem_wr, w_wb_wr;
  assign w_ex_wr  = r_ex_v & r_ex_we & (r_ex_wreg != '0);
  assign w_mem_wr = r_mem_v & r_mem_we & (r_mem_wreg != '0);
  // Without WB forwarding the register file bypasses internally.
  assign w_wb_wr  = WB_FWD & r_wb_v & r_wb_we & (r_wb_wreg != '0);

  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  assign w_ex_a  = w_ex_wr & i_id_re1 & (i_id_rs == r_ex_wreg);
  assign w_ex_b  = w_ex_wr & i_id_re2 & (i_id_rt == r_ex_wreg);
  assign w_mem_a = w_mem_wr & i_id_re1 & (i_id_rs == r_mem_wreg);
  assign w_mem_b = w_mem_wr & i_id_re2 & (i_id_rt == r_mem_wreg);
  assign w_wb_a  = w_wb_wr & i_id_re1 & (i_id_rs == r_wb_wreg);
  assign w_wb_b  = w_wb_wr & i_id_re2 & (i_id_rt == r_wb_wreg);

  // Youngest writer wins.
  logic [1:0] w_fwd_a, w_fwd_b;
  always_comb begin
    w_fwd_a = 2'b00;
    if (w_ex_a)       w_fwd_a = 2'b01;
    else if (w_mem_a) w_fwd_a = 2'b10;
    else if (w_wb_a)  w_fwd_a = 2'b11;
    w_fwd_b = 2'b00;
    if (w_ex_b)       w_fwd_b = 2'b01;
    else if (w_mem_b) w_fwd_b = 2'b10;
    else if (w_wb_b)  w_fwd_b = 2'b11;
  end

  // A load in EX has no data yet, so a match against it must stall.
  logic w_luse, w_freeze, w_redir;
  assign w_luse   = i_id_valid & r_ex_lw & (w_ex_a | w_ex_b);
  assign w_freeze = ~i_mem_ready;
  assign w_redir  = i_branch_taken | i_jump;

  // Priority: freeze > redirect > load-use > normal issue.
  logic w_stall, w_flush, w_issue, w_shift, w_ex_load;
  always_comb begin
    w_stall   = 1'b0;
    w_flush   = 1'b0;
    w_issue   = 1'b0;
    w_shift   = 1'b1;
    w_ex_load = 1'b0;
    if (w_freeze) begin
      w_stall = 1'b1;
      w_shift = 1'b0;
    end else if (w_redir) begin
      // Wrong-path ID instruction: any load-use it would cause is dropped.
      w_flush = 1'b1;
    end else if (w_luse) begin
      w_stall = 1'b1;
    end else begin
      w_issue   = i_id_valid;
      w_ex_load = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_v  <= 1'b0; r_ex_we  <= 1'b0; r_ex_lw  <= 1'b0; r_ex_wreg  <= '0;
      r_mem_v <= 1'b0; r_mem_we <= 1'b0; r_mem_lw <= 1'b0; r_mem_wreg <= '0;
      r_wb_v  <= 1'b0; r_wb_we  <= 1'b0; r_wb_lw  <= 1'b0; r_wb_wreg  <= '0;
    end else if (w_shift) begin
      r_wb_v   <= r_mem_v;
      r_wb_we  <= r_mem_we;
      r_wb_lw  <= r_mem_lw;
      r_wb_wreg <= r_mem_wreg;
      r_mem_v  <= r_ex_v;
      r_mem_we <= r_ex_we;
      r_mem_lw <= r_ex_lw;
      r_mem_wreg <= r_ex_wreg;
      if (w_ex_load) begin
        r_ex_v    <= i_id_valid;
        r_ex_we   <= i_id_valid & i_id_we;
        r_ex_lw   <= i_id_valid & i_id_lw;
        r_ex_wreg <= i_id_wreg;
      end else begin
        r_ex_v    <= 1'b0;
        r_ex_we   <= 1'b0;
        r_ex_lw   <= 1'b0;
        r_ex_wreg <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (w_stall && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  // All outputs are held low while reset is asserted.
  assign o_fwd_a       = i_rst ? 2'b00 : w_fwd_a;
  assign o_fwd_b       = i_rst ? 2'b00 : w_fwd_b;
  assign o_stall_if    = ~i_rst & w_stall;
  assign o_stall_id    = ~i_rst & w_stall;
  assign o_flush_if    = ~i_rst & w_flush;
  assign o_issue       = ~i_rst & w_issue;
  assign o_stall_count = i_rst ? '0 : r_stall_count;

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  logic       clk;
  logic       rst;
  logic       id_valid, id_re1, id_re2, id_we, id_lw;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       branch_taken, jump, mem_ready;

  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic        stall_if, stall_id, flush_if, issue;
  logic        stall_if2, stall_id2, flush_if2, issue2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  hazard_scheduler u_dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_re1(id_re1), .i_id_re2(id_re2), .i_id_we(id_we), .i_id_lw(id_lw),
    .i_id_wreg(id_wreg), .i_branch_taken(branch_taken), .i_jump(jump),
    .i_mem_ready(mem_ready), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall_if(stall_if),
    .o_stall_id(stall_id), .o_flush_if(flush_if), .o_issue(issue),
    .o_stall_count(stall_count)
  );

  // Same stimulus, no WB forwarding and a 2-bit counter.
  hazard_scheduler #(.CNT_W(2), .WB_FWD(1'b0)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_re1(id_re1), .i_id_re2(id_re2), .i_id_we(id_we), .i_id_lw(id_lw),
    .i_id_wreg(id_wreg), .i_branch_taken(branch_taken), .i_jump(jump),
    .i_mem_ready(mem_ready), .o_fwd_a(fwd_a2), .o_fwd_b(fwd_b2), .o_stall_if(stall_if2),
    .o_stall_id(stall_id2), .o_flush_if(flush_if2), .o_issue(issue2),
    .o_stall_count(stall_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vld;
    logic [4:0] rs, rt;
    logic       re1, re2, we, lw;
    logic [4:0] wreg;
    logic       br, jmp, rdy;
    logic [1:0] fa, fb;
    logic       sif, sid, fl, iss;
  } vec_t;

  typedef struct {
    logic [1:0]  fa, fb, a2, b2;
    logic        sif, sid, fl, iss;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int idx = 0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_cnt2 = '0;

  function automatic vec_t mk(input logic r, vl, input int rs, rt, input logic r1, r2, w, l,
                              input int wr, input logic b, j, rd, input int fa, fb,
                              input logic si, sd, f, is);
    vec_t v;
    v.rst = r; v.vld = vl; v.rs = 5'(rs); v.rt = 5'(rt); v.re1 = r1; v.re2 = r2;
    v.we = w; v.lw = l; v.wreg = 5'(wr); v.br = b; v.jmp = j; v.rdy = rd;
    v.fa = 2'(fa); v.fb = 2'(fb); v.sif = si; v.sid = sd; v.fl = f; v.iss = is;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL vec%0d scoreboard: got empty queue expected an entry", idx);
      return;
    end
    e = exp_q.pop_front();
    cmp("fwd_a", 16'(fwd_a), 16'(e.fa));
    cmp("fwd_b", 16'(fwd_b), 16'(e.fb));
    cmp("stall_if", 16'(stall_if), 16'(e.sif));
    cmp("stall_id", 16'(stall_id), 16'(e.sid));
    cmp("flush_if", 16'(flush_if), 16'(e.fl));
    cmp("issue", 16'(issue), 16'(e.iss));
    cmp("stall_count", stall_count, e.cnt);
    cmp("nowb_fwd_a", 16'(fwd_a2), 16'(e.a2));
    cmp("nowb_fwd_b", 16'(fwd_b2), 16'(e.b2));
    cmp("nowb_stall_id", 16'(stall_id2), 16'(e.sid));
    cmp("cnt2_stall_count", 16'(stall_count2), 16'(e.cnt2));
  endtask

  // Drive one cycle of stimulus, queue its expectation, check at the falling edge.
  task automatic drive(input vec_t v);
    exp_t e;
    rst = v.rst; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_re1 = v.re1;
    id_re2 = v.re2; id_we = v.we; id_lw = v.lw; id_wreg = v.wreg;
    branch_taken = v.br; jump = v.jmp; mem_ready = v.rdy;
    e.fa = v.fa; e.fb = v.fb; e.sif = v.sif; e.sid = v.sid; e.fl = v.fl; e.iss = v.iss;
    // Without WB forwarding a WB-sourced operand falls back to the register file.
    e.a2 = (v.fa == 2'b11) ? 2'b00 : v.fa;
    e.b2 = (v.fb == 2'b11) ? 2'b00 : v.fb;
    e.cnt  = v.rst ? 16'd0 : m_cnt;
    e.cnt2 = v.rst ? 2'd0 : m_cnt2;
    exp_q.push_back(e);
    if (v.rst) begin
      m_cnt = '0;
      m_cnt2 = '0;
    end else if (v.sid) begin
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    idx++;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_re1 = 0; id_re2 = 0;
    id_we = 0; id_lw = 0; id_wreg = 0; branch_taken = 0; jump = 0; mem_ready = 1;

    //              rst vld rs rt r1 r2 we lw wr br jp rd  fa fb si sd fl is
    vecs.push_back(mk(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    // EX then MEM then WB forwarding of add r3
    vecs.push_back(mk(0, 1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 0, 1, 0, 1, 0, 8, 0, 0, 1,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 9, 3, 1, 1, 0, 0, 0, 0, 0, 1,  0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 8, 1, 1, 0, 0, 0, 0, 0, 1,  3, 2, 0, 0, 0, 1));
    // Load-use on rt: one stall cycle, then MEM forward
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 5, 1, 1, 1, 0, 6, 0, 0, 1,  0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 5, 1, 1, 1, 0, 6, 0, 0, 1,  0, 2, 0, 0, 0, 1));
    // r0 never matches; priority EX > MEM > WB
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 0, 7, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6, 0, 1, 0, 1, 0, 7, 0, 0, 1,  3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 0));
    // Branch beats load-use; next cycle EX is a bubble
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4, 0, 1, 0, 1, 0, 5, 1, 0, 1,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 1));
    // Freeze for 3 cycles with a pending jump; slots hold, then the jump flushes
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0,  1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 0, 1, 0, 1, 1, 9, 0, 0, 1,  2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 9, 1, 1, 0, 0, 0, 0, 0, 1,  3, 1, 1, 1, 0, 0));
    // Fill all slots, reset, then nothing forwards
    vecs.push_back(mk(0, 1, 0, 9, 0, 1, 1, 0, 10, 0, 0, 1, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 11, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 12, 11, 1, 1, 1, 0, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 12, 11, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) drive(vecs[i]);

    // Saturation: reset, five frozen cycles, then one idle cycle shows 5 and 3.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Reset asserted during a freeze still forces every output low.
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    cmp("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
